// File: rtl/hazard_forwarding_controller.sv
// hazard_forwarding_controller: ID-stage operand forwarding, load-use stall and branch flush control
// with a saturating stall-cycle counter.
module hazard_forwarding_controller #(
   parameter int REG_AW       = 5,
   parameter int LOAD_LAT     = 1,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rs3,
   input  logic [2:0]        src_use,
   input  logic [REG_AW-1:0] ex_destination,
   input  logic [REG_AW-1:0] mem_destination,
   input  logic [REG_AW-1:0] wb_destination,
   input  logic              ex_rf_enable,
   input  logic              mem_rf_enable,
   input  logic              wb_rf_enable,
   input  logic              ex_load_instruction,
   input  logic              branch_taken,
   input  logic              stat_clear,
   output logic [1:0]        pa_selector,
   output logic [1:0]        pb_selector,
   output logic [1:0]        pc_selector,
   output logic              load_enable,
   output logic              pc_enable,
   output logic              nop_signal,
   output logic              flush,
   output logic [CNT_W-1:0]  stall_count
);
   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
   state_t state, state_nx;
   logic [2:0] cnt, cnt_nx;
   logic [REG_AW-1:0] rs [3];
   logic [2:0] ex_m, mem_m, wb_m;
   logic hazard, flush_mode, stall_mode, fwd;
   assign rs = '{id_rs1, id_rs2, id_rs3};
   for (genvar i = 0; i < 3; i++) begin : g_match
      logic live;
      assign live     = src_use[i] && rs[i] != '0;
      assign ex_m[i]  = live && ex_rf_enable  && rs[i] == ex_destination;
      assign mem_m[i] = live && mem_rf_enable && rs[i] == mem_destination;
      assign wb_m[i]  = live && wb_rf_enable  && rs[i] == wb_destination;
   end
   assign hazard = ex_load_instruction && |ex_m;
   function automatic logic [1:0] pick(input logic e, input logic m, input logic w);
      return e ? 2'b01 : m ? 2'b10 : w ? 2'b11 : 2'b00;
   endfunction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         RUN: begin
            if (branch_taken) begin
               state_nx = FLUSH_CYCLES > 1 ? FLUSH : RUN;
               cnt_nx   = 3'(FLUSH_CYCLES - 1);
            end else if (hazard) begin
               state_nx = LOAD_LAT > 1 ? STALL : RUN;
               cnt_nx   = 3'(LOAD_LAT - 1);
            end
         end
         STALL: begin
            if (branch_taken) begin
               state_nx = FLUSH_CYCLES > 1 ? FLUSH : RUN;
               cnt_nx   = 3'(FLUSH_CYCLES - 1);
            end else begin
               state_nx = cnt == 3'd1 ? RUN : STALL;
               cnt_nx   = cnt - 3'd1;
            end
         end
         FLUSH: begin
            state_nx = cnt == 3'd1 ? RUN : FLUSH;
            cnt_nx   = cnt - 3'd1;
         end
         default: state_nx = RUN;
      endcase
   end
   // Branch flush wins over any stall; FLUSH ignores branch_taken but is a flush anyway.
   always_comb begin
      flush_mode  = !reset && (state == FLUSH || branch_taken);
      stall_mode  = !reset && !flush_mode && (state == STALL || hazard);
      fwd         = !reset && !flush_mode && !stall_mode;
      load_enable = !stall_mode;
      pc_enable   = !stall_mode;
      nop_signal  = flush_mode || stall_mode;
      flush       = flush_mode;
      pa_selector = fwd ? pick(ex_m[0], mem_m[0], wb_m[0]) : 2'b00;
      pb_selector = fwd ? pick(ex_m[1], mem_m[1], wb_m[1]) : 2'b00;
      pc_selector = fwd ? pick(ex_m[2], mem_m[2], wb_m[2]) : 2'b00;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_count <= '0;
      else if (stat_clear)
         stall_count <= '0;
      else if (!pc_enable && !(&stall_count))
         stall_count <= stall_count + 1'b1;
   end
endmodule
